// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-cycle sequencer and instruction register.
// Walks FETCH -> EXEC1 -> (EXEC2) -> FETCH, parks in HALT on a stop
// request, after each instruction in single-step mode, or out of reset
// when auto-start is disabled. Also counts retired instructions.
module fetch_sequencer #(
  parameter bit          AUTO_START = 1'b1,
  parameter int          CNT_W      = 32,
  parameter logic [15:0] IR_RST     = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      ram_q,
  input  logic             sm_extra,
  input  logic             stop,
  input  logic             step_mode,
  input  logic             go,
  output logic [15:0]      instruction,
  output logic [1:0]       state,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] retired
);

  // The encoding is visible to the decoder, so these values are fixed.
  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC1 = 2'b01,
    ST_EXEC2 = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  localparam logic [1:0] CAUSE_IDLE = 2'b00;
  localparam logic [1:0] CAUSE_STOP = 2'b01;
  localparam logic [1:0] CAUSE_STEP = 2'b10;

  localparam state_t RST_STATE = AUTO_START ? ST_FETCH : ST_HALT;

  state_t             state_r;
  state_t             state_s;
  logic [15:0]        ir_r;
  logic [15:0]        ir_s;
  logic [1:0]         cause_r;
  logic [1:0]         cause_s;
  logic [CNT_W-1:0]   retired_r;
  logic [CNT_W-1:0]   retired_s;
  logic               finish_s;

  // Counter increment that wraps silently at 2^CNT_W.
  function automatic logic [CNT_W-1:0] incr_wrap(input logic [CNT_W-1:0] val);
    incr_wrap = val + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Next-state, IR capture, halt cause and retire decisions.
  always_comb begin
    state_s   = state_r;
    ir_s      = ir_r;
    cause_s   = cause_r;
    retired_s = retired_r;
    finish_s  = 1'b0;

    case (state_r)
      ST_FETCH: begin
        // The only edge on which the IR loads; stop is not looked at here.
        state_s = ST_EXEC1;
        ir_s    = ram_q;
      end
      ST_EXEC1: begin
        // A stop request beats the need for a second execute cycle.
        if (stop) begin
          state_s = ST_HALT;
          cause_s = CAUSE_STOP;
        end else if (sm_extra) begin
          state_s = ST_EXEC2;
        end else begin
          finish_s = 1'b1;
        end
      end
      ST_EXEC2: begin
        if (stop) begin
          state_s = ST_HALT;
          cause_s = CAUSE_STOP;
        end else begin
          finish_s = 1'b1;
        end
      end
      ST_HALT: begin
        if (go) begin
          state_s = ST_FETCH;
          cause_s = CAUSE_IDLE;
        end else begin
          state_s = ST_HALT;
        end
      end
      default: begin
        state_s = ST_HALT;
        cause_s = CAUSE_IDLE;
      end
    endcase

    // step_mode is only consulted when an instruction actually completes.
    if (finish_s) begin
      retired_s = incr_wrap(retired_r);
      if (step_mode) begin
        state_s = ST_HALT;
        cause_s = CAUSE_STEP;
      end else begin
        state_s = ST_FETCH;
      end
    end else begin
      retired_s = retired_s;
    end
  end

  // State, IR, cause and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= RST_STATE;
      ir_r      <= IR_RST;
      cause_r   <= CAUSE_IDLE;
      retired_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_s;
      ir_r      <= ir_s;
      cause_r   <= cause_s;
      retired_r <= retired_s;
    end
  end

  assign state       = state_r;
  assign instruction = ir_r;
  assign halt_cause  = cause_r;
  assign retired     = retired_r;
  // Plain decode of the state register; no input reaches it.
  assign halted      = (state_r == ST_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a hand-written vector table, a counter wrap
// sequence and a randomized run, all checked against expected values held in
// the bench. Two instances share the inputs: A (auto-start, 32-bit counter)
// and B (start halted, 4-bit counter, non-zero IR reset value).
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ram_q;
  logic        sm_extra, stop, step_mode, go;

  logic [15:0] ir_a, ir_b;
  logic [1:0]  st_a, st_b, cause_a, cause_b;
  logic        hlt_a, hlt_b;
  logic [31:0] ret_a;
  logic [3:0]  ret_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.AUTO_START(1'b1), .CNT_W(32), .IR_RST(16'h0000)) dut_a (
    .clk(clk), .rst_n(rst_n), .ram_q(ram_q), .sm_extra(sm_extra), .stop(stop),
    .step_mode(step_mode), .go(go), .instruction(ir_a), .state(st_a),
    .halted(hlt_a), .halt_cause(cause_a), .retired(ret_a));

  fetch_sequencer #(.AUTO_START(1'b0), .CNT_W(4), .IR_RST(16'hA5C3)) dut_b (
    .clk(clk), .rst_n(rst_n), .ram_q(ram_q), .sm_extra(sm_extra), .stop(stop),
    .step_mode(step_mode), .go(go), .instruction(ir_b), .state(st_b),
    .halted(hlt_b), .halt_cause(cause_b), .retired(ret_b));

  // Reference model: per instance, whether it is parked, which cycle of the
  // current instruction it is in (0 fetch, 1 first exec, 2 second exec), why
  // it parked, the IR, and the retire count.
  bit          m_hlt   [2];
  int          m_pos   [2];
  logic [1:0]  m_cause [2];
  logic [15:0] m_ir    [2];
  longint      m_ret   [2];
  bit          m_auto  [2] = '{1'b1, 1'b0};
  logic [15:0] m_irrst [2] = '{16'h0000, 16'hA5C3};
  longint      m_mask  [2] = '{64'hFFFF_FFFF, 64'hF};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_hlt[k] = !m_auto[k]; m_pos[k] = 0; m_ir[k] = m_irrst[k];
        m_cause[k] = 2'd0; m_ret[k] = 0;
      end else if (m_hlt[k]) begin
        if (go) begin m_hlt[k] = 1'b0; m_pos[k] = 0; m_cause[k] = 2'd0; end
      end else if (m_pos[k] == 0) begin
        m_ir[k] = ram_q; m_pos[k] = 1;
      end else if (stop) begin
        m_hlt[k] = 1'b1; m_cause[k] = 2'd1;
      end else if (m_pos[k] == 1 && sm_extra) begin
        m_pos[k] = 2;
      end else begin
        m_ret[k] = (m_ret[k] + 1) & m_mask[k];
        m_pos[k] = 0;
        if (step_mode) begin m_hlt[k] = 1'b1; m_cause[k] = 2'd2; end
      end
    end
  endtask

  task automatic check_model();
    logic [1:0] es0, es1;
    es0 = m_hlt[0] ? 2'd3 : 2'(m_pos[0]);
    es1 = m_hlt[1] ? 2'd3 : 2'(m_pos[1]);
    chk("a_state", 64'(st_a), 64'(es0));
    chk("a_ir", 64'(ir_a), 64'(m_ir[0]));
    chk("a_halted", 64'(hlt_a), 64'(m_hlt[0]));
    chk("a_cause", 64'(cause_a), 64'(m_cause[0]));
    chk("a_retired", 64'(ret_a), 64'(m_ret[0]));
    chk("b_state", 64'(st_b), 64'(es1));
    chk("b_ir", 64'(ir_b), 64'(m_ir[1]));
    chk("b_halted", 64'(hlt_b), 64'(m_hlt[1]));
    chk("b_cause", 64'(cause_b), 64'(m_cause[1]));
    chk("b_retired", 64'(ret_b), 64'(m_ret[1]));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    logic        rst_n;
    logic [15:0] ram_q;
    logic        sm, stp, step, go;
    logic [1:0]  e_state;
    logic [15:0] e_ir;
    logic [31:0] e_ret;
    logic [1:0]  e_cause;
  } vec_t;

  vec_t vt[25];

  initial begin
    // rst ram sm stp step go | state ir ret cause   (expectations for instance A)
    vt[0]  = '{1'b0, 16'h5B12, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 32'd0, 2'd0};
    vt[1]  = '{1'b0, 16'h5B12, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 32'd0, 2'd0};
    vt[2]  = '{1'b1, 16'h5B12, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 16'h5B12, 32'd0, 2'd0};
    vt[3]  = '{1'b1, 16'h5B12, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h5B12, 32'd1, 2'd0};
    vt[4]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 16'h1234, 32'd1, 2'd0};
    vt[5]  = '{1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 16'h1234, 32'd1, 2'd0};
    vt[6]  = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h1234, 32'd2, 2'd0};
    vt[7]  = '{1'b1, 16'h7777, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 16'h7777, 32'd2, 2'd0};
    vt[8]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 16'h7777, 32'd2, 2'd1};
    vt[9]  = '{1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 16'h7777, 32'd2, 2'd1};
    vt[10] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 16'h7777, 32'd2, 2'd0};
    vt[11] = '{1'b1, 16'h0042, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 16'h0042, 32'd2, 2'd0};
    vt[12] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0042, 32'd3, 2'd0};
    vt[13] = '{1'b1, 16'h0043, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 16'h0043, 32'd3, 2'd0};
    vt[14] = '{1'b1, 16'h0043, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 16'h0043, 32'd4, 2'd2};
    vt[15] = '{1'b1, 16'h0043, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 16'h0043, 32'd4, 2'd2};
    vt[16] = '{1'b1, 16'h0043, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 16'h0043, 32'd4, 2'd0};
    vt[17] = '{1'b1, 16'h0044, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 16'h0044, 32'd4, 2'd0};
    vt[18] = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 16'h0044, 32'd4, 2'd0};
    vt[19] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 16'h0044, 32'd5, 2'd2};
    vt[20] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 16'h0044, 32'd5, 2'd0};
    vt[21] = '{1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 16'h5555, 32'd5, 2'd0};
    vt[22] = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 16'h5555, 32'd5, 2'd0};
    vt[23] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 32'd0, 2'd0};
    vt[24] = '{1'b1, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 16'h0101, 32'd0, 2'd0};

    rst_n = 1'b0; ram_q = 16'h0000; sm_extra = 1'b0; stop = 1'b0;
    step_mode = 1'b0; go = 1'b0;
    @(negedge clk);

    // Table: directed sequences for instance A, model check on both.
    for (int i = 0; i < 25; i++) begin
      rst_n = vt[i].rst_n; ram_q = vt[i].ram_q; sm_extra = vt[i].sm;
      stop = vt[i].stp; step_mode = vt[i].step; go = vt[i].go;
      tick();
      chk($sformatf("vec%0d_state", i), 64'(st_a), 64'(vt[i].e_state));
      chk($sformatf("vec%0d_ir", i), 64'(ir_a), 64'(vt[i].e_ir));
      chk($sformatf("vec%0d_retired", i), 64'(ret_a), 64'(vt[i].e_ret));
      chk($sformatf("vec%0d_cause", i), 64'(cause_a), 64'(vt[i].e_cause));
      chk($sformatf("vec%0d_halted", i), 64'(hlt_a), 64'(vt[i].e_state == 2'd3));
    end

    // Instance B: starts halted, then 16 plain instructions wrap the counter.
    rst_n = 1'b0; go = 1'b0; stop = 1'b0; sm_extra = 1'b0; step_mode = 1'b0;
    tick();
    chk("b_rst_state", 64'(st_b), 64'd3);
    chk("b_rst_cause", 64'(cause_b), 64'd0);
    chk("b_rst_ir", 64'(ir_b), 64'hA5C3);
    rst_n = 1'b1;
    tick();
    chk("b_idle_hold", 64'(st_b), 64'd3);
    go = 1'b1;
    tick();
    chk("b_go_fetch", 64'(st_b), 64'd0);
    go = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      ram_q = 16'(i * 16'h0111);
      tick();
      tick();
      chk($sformatf("b_wrap_%0d", i), 64'(ret_b), 64'(i % 16));
    end

    // Randomized run against the model.
    for (int c = 0; c < 4000; c++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      ram_q     = 16'($urandom);
      sm_extra  = 1'($urandom);
      stop      = ($urandom_range(0, 7) == 0);
      go        = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 15) == 0) step_mode = ~step_mode;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
